// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard controller.
//   FS_RUN / FS_STALL / FS_FLUSH : per-register flush_and_stall codes
//                                  (bit0 = stall, bit1 = flush)
//   hz_state_t                   : controller FSM states
//   load_use()                   : load-use hazard detector
package hazard_pkg;

  localparam logic [1:0] FS_RUN   = 2'b00;
  localparam logic [1:0] FS_STALL = 2'b01;
  localparam logic [1:0] FS_FLUSH = 2'b10;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } hz_state_t;

  // x0 is hardwired to zero, so a load "to x0" never creates a dependency.
  function automatic logic load_use(input logic       memread,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    return memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: free-running performance counters for the hazard controller.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   stall_i            : PC stalled this cycle
//   flush_i            : EX/MEM flushed this cycle
//   stall_cycles_o     : count of stalled cycles (wraps mod 2^32)
//   flushes_o          : count of EX/MEM flush cycles (wraps mod 2^32)
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flushes_o
);

  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q + (stall_i ? 32'd1 : 32'd0);
    flush_d = flush_q + (flush_i ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flushes_o      = flush_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central hazard controller for the 5-stage RISC-V pipeline.
// Resolves load-use hazards, MEM-stage branch redirects and instruction/data
// bus wait states. A redirect that arrives while a fetch is outstanding is
// parked in tgt_q (REDIRECT state) until the fetch completes.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   if_busy, mem_busy           : instruction / data bus wait states
//   id_rs1_addr, id_rs2_addr    : sources of the instruction in ID
//   ex_memread, ex_rd_addr      : load flag and destination of the instruction in EX
//   branch_taken, branch_target : taken branch resolved in MEM and its target
//   pc_stall, pc_sel, pc_target : PC hold / redirect control
//   ifid_fs .. memwb_fs         : per pipeline register control (bit0 stall, bit1 flush)
// Optional: define HAZARD_PERF_CNT_EN to add perf_stall_cycles / perf_flushes.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_busy,
  input  logic                  mem_busy,
  input  logic [4:0]            id_rs1_addr,
  input  logic [4:0]            id_rs2_addr,
  input  logic                  ex_memread,
  input  logic [4:0]            ex_rd_addr,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  pc_stall,
  output logic                  pc_sel,
  output logic [ADDR_WIDTH-1:0] pc_target,
  output logic [1:0]            ifid_fs,
  output logic [1:0]            idex_fs,
  output logic [1:0]            exmem_fs,
  output logic [1:0]            memwb_fs
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flushes
`endif
);

  hz_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic                  lu;

  assign lu = load_use(ex_memread, ex_rd_addr, id_rs1_addr, id_rs2_addr);

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    pc_stall  = 1'b0;
    pc_sel    = 1'b0;
    pc_target = (state_q == REDIRECT) ? tgt_q : branch_target;
    ifid_fs   = FS_RUN;
    idex_fs   = FS_RUN;
    exmem_fs  = FS_RUN;
    memwb_fs  = FS_RUN;

    if (reset) begin
      // Outputs follow reset immediately, independent of the clock.
      state_d   = RUN;
      tgt_d     = '0;
      pc_stall  = 1'b1;
      pc_target = '0;
      ifid_fs   = FS_FLUSH;
      idex_fs   = FS_FLUSH;
      exmem_fs  = FS_FLUSH;
      memwb_fs  = FS_FLUSH;
    end else if (state_q == RUN) begin
      if (mem_busy) begin
        // A pending branch waits here too: EX/MEM is held, so branch_taken
        // stays asserted until the data access completes.
        pc_stall = 1'b1;
        ifid_fs  = FS_STALL;
        idex_fs  = FS_STALL;
        exmem_fs = FS_STALL;
        memwb_fs = FS_FLUSH;
      end else if (branch_taken) begin
        ifid_fs  = FS_FLUSH;
        idex_fs  = FS_FLUSH;
        exmem_fs = FS_FLUSH;
        if (!if_busy) begin
          pc_sel = 1'b1;
        end else begin
          // Fetch still in flight: the PC cannot be reloaded yet, park target.
          pc_stall = 1'b1;
          tgt_d    = branch_target;
          state_d  = REDIRECT;
        end
      end else if (lu) begin
        pc_stall = 1'b1;
        ifid_fs  = FS_STALL;
        idex_fs  = FS_FLUSH;
      end else if (if_busy) begin
        pc_stall = 1'b1;
        ifid_fs  = FS_FLUSH;
      end
    end else begin
      // REDIRECT: older stages are already flushed, so branch_taken and lu
      // are ignored; every fetch returning now is wrong-path.
      ifid_fs = FS_FLUSH;
      if (mem_busy) begin
        pc_stall = 1'b1;
        idex_fs  = FS_STALL;
        exmem_fs = FS_STALL;
        memwb_fs = FS_FLUSH;
      end else if (if_busy) begin
        pc_stall = 1'b1;
      end else begin
        pc_sel  = 1'b1;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (pc_stall),
    .flush_i        (exmem_fs == FS_FLUSH),
    .stall_cycles_o (perf_stall_cycles),
    .flushes_o      (perf_flushes)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl.
// Control outputs are compared as one vector:
//   {pc_stall, pc_sel, ifid_fs, idex_fs, exmem_fs, memwb_fs}
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_busy, mem_busy;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        ex_memread;
  logic [4:0]  ex_rd_addr;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        pc_stall, pc_sel;
  logic [31:0] pc_target;
  logic [1:0]  ifid_fs, idex_fs, exmem_fs, memwb_fs;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
`endif

  logic [9:0]  ctl;
  int          total  = 0;
  int          passed = 0;

  assign ctl = {pc_stall, pc_sel, ifid_fs, idex_fs, exmem_fs, memwb_fs};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_busy       (if_busy),
    .mem_busy      (mem_busy),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .ex_memread    (ex_memread),
    .ex_rd_addr    (ex_rd_addr),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_stall      (pc_stall),
    .pc_sel        (pc_sel),
    .pc_target     (pc_target),
    .ifid_fs       (ifid_fs),
    .idex_fs       (idex_fs),
    .exmem_fs      (exmem_fs),
    .memwb_fs      (memwb_fs)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  // Expected control vectors, written out by hand.
  localparam logic [9:0] C_IDLE   = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [9:0] C_RESET  = {1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 2'b10};
  localparam logic [9:0] C_MEMBSY = {1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 2'b10};
  localparam logic [9:0] C_BR_NOW = {1'b0, 1'b1, 2'b10, 2'b10, 2'b10, 2'b00};
  localparam logic [9:0] C_BR_DLY = {1'b1, 1'b0, 2'b10, 2'b10, 2'b10, 2'b00};
  localparam logic [9:0] C_LU     = {1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00};
  localparam logic [9:0] C_IFBSY  = {1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [9:0] C_RD_IF  = {1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [9:0] C_RD_MEM = {1'b1, 1'b0, 2'b10, 2'b01, 2'b01, 2'b10};
  localparam logic [9:0] C_RD_GO  = {1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00};

  task automatic idle_inputs();
    if_busy       = 1'b0;
    mem_busy      = 1'b0;
    id_rs1_addr   = 5'd0;
    id_rs2_addr   = 5'd0;
    ex_memread    = 1'b0;
    ex_rd_addr    = 5'd0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h1234_5678;
    #2;
    total++;
    if (ctl !== C_RESET) $display("FAIL reset_ctl: got %b expected %b", ctl, C_RESET);
    else passed++;
    total++;
    if (pc_target !== 32'h0) $display("FAIL reset_target: got %h expected %h", pc_target, 32'h0);
    else passed++;
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    #1;
    total++;
    if (ctl !== C_IDLE) $display("FAIL post_reset_idle: got %b expected %b", ctl, C_IDLE);
    else passed++;
  endtask

  task automatic test_load_use();
    next_cycle();
    ex_memread = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_rs2_addr = 5'd9;
    #1;
    total++;
    if (ctl !== C_LU) $display("FAIL lu_rs1: got %b expected %b", ctl, C_LU);
    else passed++;
    next_cycle();
    idle_inputs();  // load has moved on to MEM
    #1;
    total++;
    if (ctl !== C_IDLE) $display("FAIL lu_one_bubble: got %b expected %b", ctl, C_IDLE);
    else passed++;
    next_cycle();
    ex_memread = 1'b1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd3; id_rs2_addr = 5'd7;
    #1;
    total++;
    if (ctl !== C_LU) $display("FAIL lu_rs2: got %b expected %b", ctl, C_LU);
    else passed++;
    next_cycle();
    ex_memread = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
    #1;
    total++;
    if (ctl !== C_IDLE) $display("FAIL lu_x0: got %b expected %b", ctl, C_IDLE);
    else passed++;
    next_cycle();
    ex_memread = 1'b0; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5;
    #1;
    total++;
    if (ctl !== C_IDLE) $display("FAIL lu_not_load: got %b expected %b", ctl, C_IDLE);
    else passed++;
    next_cycle();
    idle_inputs();
    if_busy = 1'b1;
    #1;
    total++;
    if (ctl !== C_IFBSY) $display("FAIL if_busy_only: got %b expected %b", ctl, C_IFBSY);
    else passed++;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_branch_idle();
    branch_taken = 1'b1; branch_target = 32'h8000_0100;
    #1;
    total++;
    if (ctl !== C_BR_NOW) $display("FAIL br_idle_ctl: got %b expected %b", ctl, C_BR_NOW);
    else passed++;
    total++;
    if (pc_target !== 32'h8000_0100) $display("FAIL br_idle_target: got %h expected %h", pc_target, 32'h8000_0100);
    else passed++;
    next_cycle();
    idle_inputs();
    #1;
    total++;
    if (ctl !== C_IDLE) $display("FAIL br_idle_after: got %b expected %b", ctl, C_IDLE);
    else passed++;
  endtask

  task automatic test_branch_busy();
    next_cycle();
    branch_taken = 1'b1; branch_target = 32'h8000_0200; if_busy = 1'b1;
    #1;
    total++;
    if (ctl !== C_BR_DLY) $display("FAIL br_busy_first: got %b expected %b", ctl, C_BR_DLY);
    else passed++;
    // Two more busy cycles in REDIRECT; branch/lu inputs must be ignored.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      branch_taken = 1'b1; branch_target = 32'hDEAD_BEEF;
      ex_memread = 1'b1; ex_rd_addr = 5'd4; id_rs1_addr = 5'd4;
      #1;
      total++;
      if (ctl !== C_RD_IF) $display("FAIL redirect_wait%0d: got %b expected %b", i, ctl, C_RD_IF);
      else passed++;
      total++;
      if (pc_target !== 32'h8000_0200) $display("FAIL redirect_tgt%0d: got %h expected %h", i, pc_target, 32'h8000_0200);
      else passed++;
    end
    next_cycle();
    idle_inputs();
    mem_busy = 1'b1;
    #1;
    total++;
    if (ctl !== C_RD_MEM) $display("FAIL redirect_membusy: got %b expected %b", ctl, C_RD_MEM);
    else passed++;
    next_cycle();
    idle_inputs();
    branch_target = 32'h0000_0044;
    #1;
    total++;
    if (ctl !== C_RD_GO) $display("FAIL redirect_go: got %b expected %b", ctl, C_RD_GO);
    else passed++;
    total++;
    if (pc_target !== 32'h8000_0200) $display("FAIL redirect_go_tgt: got %h expected %h", pc_target, 32'h8000_0200);
    else passed++;
    next_cycle();
    idle_inputs();
    #1;
    total++;
    if (ctl !== C_IDLE) $display("FAIL redirect_back_run: got %b expected %b", ctl, C_IDLE);
    else passed++;
  endtask

  task automatic test_data_stall();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      idle_inputs();
      mem_busy = 1'b1;
      #1;
      total++;
      if (ctl !== C_MEMBSY) $display("FAIL data_stall%0d: got %b expected %b", i, ctl, C_MEMBSY);
      else passed++;
    end
    next_cycle();
    idle_inputs();
    #1;
    total++;
    if (ctl !== C_IDLE) $display("FAIL data_resume: got %b expected %b", ctl, C_IDLE);
    else passed++;
  endtask

  task automatic test_priority();
    next_cycle();
    mem_busy = 1'b1; branch_taken = 1'b1; branch_target = 32'h8000_0300;
    ex_memread = 1'b1; ex_rd_addr = 5'd6; id_rs2_addr = 5'd6;
    #1;
    total++;
    if (ctl !== C_MEMBSY) $display("FAIL prio_mem: got %b expected %b", ctl, C_MEMBSY);
    else passed++;
    next_cycle();
    mem_busy = 1'b0;
    #1;
    total++;
    if (ctl !== C_BR_NOW) $display("FAIL prio_branch: got %b expected %b", ctl, C_BR_NOW);
    else passed++;
    total++;
    if (pc_target !== 32'h8000_0300) $display("FAIL prio_target: got %h expected %h", pc_target, 32'h8000_0300);
    else passed++;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_in_redirect();
    branch_taken = 1'b1; branch_target = 32'h8000_0400; if_busy = 1'b1;
    next_cycle();  // now in REDIRECT
    idle_inputs();
    if_busy = 1'b1;
    #1;
    total++;
    if (ctl !== C_RD_IF) $display("FAIL rr_in_redirect: got %b expected %b", ctl, C_RD_IF);
    else passed++;
    // Pulse reset between clock edges: the state must clear without a clock.
    reset = 1'b1;
    #1;
    total++;
    if (ctl !== C_RESET) $display("FAIL rr_reset_ctl: got %b expected %b", ctl, C_RESET);
    else passed++;
    total++;
    if (pc_target !== 32'h0) $display("FAIL rr_reset_tgt: got %h expected %h", pc_target, 32'h0);
    else passed++;
    #1;
    reset   = 1'b0;
    if_busy = 1'b0;
    #1;
    total++;
    if (ctl !== C_IDLE) $display("FAIL rr_after_release: got %b expected %b", ctl, C_IDLE);
    else passed++;
    next_cycle();
    #1;
    total++;
    if (ctl !== C_IDLE) $display("FAIL rr_next_cycle: got %b expected %b", ctl, C_IDLE);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_idle();
    test_branch_busy();
    test_data_stall();
    test_priority();
    test_reset_in_redirect();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard controller for the 5-stage RISC-V pipeline. It generates the 2-bit `flush_and_stall` control for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus PC stall and redirect. It resolves load-use hazards, branch redirects from the MEM stage, and instruction-bus and data-bus wait states. A small FSM holds a branch redirect until an in-flight instruction fetch completes.

## Interface
- `ADDR_WIDTH`, 32, PC/target width
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `if_busy`  in  1  instruction-bus fetch outstanding, not acked this cycle
- `mem_busy`  in  1  data-bus load/store outstanding in MEM stage
- `id_rs1_addr`, `id_rs2_addr`  in  5 each  source registers of instruction in ID
- `ex_memread`  in  1  instruction in EX is a load
- `ex_rd_addr`  in  5  destination register of instruction in EX
- `branch_taken`  in  1  branch/jump resolved taken in MEM stage
- `branch_target`  in  ADDR_WIDTH  redirect address accompanying `branch_taken`
- `pc_stall`  out  1  hold PC
- `pc_sel`  out  1  load PC from `pc_target` this cycle
- `pc_target`  out  ADDR_WIDTH  redirect address
- `ifid_fs`, `idex_fs`, `exmem_fs`, `memwb_fs`  out  2 each  bit0 = stall, bit1 = flush (flush dominates in the registers)

## Operation
- Encoding per register:
  - 00 = advance
  - 01 = hold
  - 10 = bubble
- FSM states: RUN, REDIRECT. Registers: `state`, `tgt_q` (ADDR_WIDTH).
- Load-use hazard `lu` is asserted when all of the following hold:
  - `ex_memread`
  - `ex_rd_addr` != 0
  - `ex_rd_addr` equals `id_rs1_addr` or `id_rs2_addr`
- RUN outputs, first matching rule wins:
  1. `mem_busy`: pc_stall=1; ifid/idex/exmem=01; memwb=10; pc_sel=0.
  2. `branch_taken`: ifid/idex/exmem=10; memwb=00.
     - If `!if_busy`: pc_sel=1, pc_target=`branch_target`, pc_stall=0.
     - Otherwise: pc_stall=1, pc_sel=0, latch `tgt_q`<=`branch_target`, next state REDIRECT.
  3. `lu`: pc_stall=1; ifid=01; idex=10; exmem/memwb=00.
  4. `if_busy`: pc_stall=1; ifid=10; others 00.
  5. Otherwise: all 00, pc_stall=0, pc_sel=0.
- REDIRECT outputs:
  - ifid=10 every cycle; this discards the wrong-path fetch.
  - If `mem_busy`: pc_stall=1, pc_sel=0, idex/exmem=01, memwb=10.
  - Else if `if_busy`: pc_stall=1, pc_sel=0, idex/exmem/memwb=00.
  - Else: pc_sel=1, pc_target=`tgt_q`, pc_stall=0, idex/exmem/memwb=00, next state RUN.
  - `branch_taken` and `lu` are ignored in REDIRECT; the path is already flushed.
- `pc_target` = `branch_target` in RUN and `tgt_q` in REDIRECT.
- All outputs are combinational from `state`, `tgt_q` and inputs.

## Timing
- While `reset` is asserted:
  - all `*_fs`=10, pc_stall=1, pc_sel=0, pc_target=0
  - `state`=RUN, `tgt_q`=0
- Reset mid-REDIRECT abandons the redirect.
- Redirect latency:
  - 0 cycles when the fetch is idle (pc_sel in the same cycle as `branch_taken`).
  - Otherwise pc_sel asserts in the first REDIRECT cycle with `!if_busy && !mem_busy`.
- Load-use inserts exactly one bubble. The next cycle, the load is in MEM and `lu` deasserts.
- `mem_busy` held N cycles stalls EX/MEM for N cycles and injects N MEM/WB bubbles. The pipeline resumes in the cycle `mem_busy` drops.
- `branch_taken` with `mem_busy` is deferred. EX/MEM is held, so `branch_taken` remains asserted until `mem_busy` clears.
- `state` and `tgt_q` update on posedge `clk` only.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: adds outputs `perf_stall_cycles` (32) and `perf_flushes` (32), reset to 0. They wrap modulo 2^32.
  - `perf_stall_cycles` increments each cycle pc_stall=1 outside reset.
  - `perf_flushes` increments each cycle exmem=10.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- `hazard_pkg` holds:
  - `FS_RUN`=2'b00, `FS_STALL`=2'b01, `FS_FLUSH`=2'b10
  - `hz_state_t` enum {RUN, REDIRECT}
- Optional sub-module `hazard_perf_cnt` holds both counters and is instantiated only under `HAZARD_PERF_CNT_EN`.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5 -> pc_stall=1, ifid=01, idex=10 for one cycle. With ex_rd=0 -> no stall.
- Branch, fetch idle: branch_taken=1, target=0x8000_0100 -> same cycle pc_sel=1, pc_target=0x8000_0100, ifid/idex/exmem=10.
- Branch, fetch busy: branch_taken=1, target=0x8000_0200, if_busy=1 for 3 cycles -> REDIRECT, ifid=10 each cycle; pc_sel=1 with 0x8000_0200 when if_busy drops, then RUN.
- Data stall: mem_busy=1 for 4 cycles -> exmem=01 and memwb=10 for 4 cycles; all 00 on the 5th.
- Priority: mem_busy+branch_taken+lu together -> mem_busy rule only. After mem_busy drops -> branch rule fires.
- Reset in REDIRECT -> outputs at reset values immediately; after release, state=RUN and pc_sel=0.
